// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM state encoding,
// default chain length, counter width and a word-count helper.
package cgra_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        SHIFT  = 3'd3,
        FINISH = 3'd4
    } cfg_ld_state_t;

    // Default chain length of the attached PE config chain.
    localparam int CFG_CHAIN_LEN = 14;

    // Width of a counter able to hold 0..CFG_CHAIN_LEN.
    localparam int CFG_BITS_W = $clog2(CFG_CHAIN_LEN + 1);

    // Number of bitstream words needed to fill a chain of len bits.
    function automatic int cfg_words(input int len, input int size);
        return (len + size - 1) / size;
    endfunction

endpackage

// File: rtl/config_chain_loader_serializer.sv
// Word-wide shift register with a per-word bit counter. A load captures a
// word and its bit count; each shift moves one bit toward the chain, LSB first.
module cfg_serializer #(
    parameter int size  = 32,
    parameter int CNT_W = $clog2(size + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [size-1:0]  word_in,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             last,
    output logic             head_next
);

    logic [size-1:0]  sreg_r;
    logic [CNT_W-1:0] cnt_r;
    logic [size-1:0]  sreg_shr_s;

    // Register contents after one right shift.
    always_comb begin
        sreg_shr_s = sreg_r >> 1;
    end

    // Capture a new word on load, otherwise drop one bit per shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            sreg_r <= word_in;
            cnt_r  <= cnt_in;
        end else if (shift) begin
            sreg_r <= sreg_shr_s;
            cnt_r  <= cnt_r - CNT_W'(1'b1);
        end else begin
            sreg_r <= sreg_r;
            cnt_r  <= cnt_r;
        end
    end

    // Look-ahead of the bit at the head of the register after this edge,
    // so the top can present it from a register in the following cycle.
    always_comb begin
        head_next = sreg_r[0];
        if (load) begin
            head_next = word_in[0];
        end else if (shift) begin
            head_next = sreg_shr_s[0];
        end else begin
            head_next = sreg_r[0];
        end
    end

    // The bit currently at the head is the final one of this word.
    always_comb begin
        last = (cnt_r == CNT_W'(1'b1));
    end

endmodule

// File: rtl/config_chain_loader.sv
// Loads a configuration bitstream into a config_cell chain: clears the
// chain, fetches words over valid/ready, shifts exactly CHAIN_LEN bits LSB
// first, then pulses done. All outputs come straight from flops.
module config_chain_loader
    import cgra_cfg_pkg::*;
#(
    parameter int size      = 32,
    parameter int CHAIN_LEN = CFG_CHAIN_LEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [size-1:0] word_in,
    input  logic            word_valid,
    output logic            word_ready,
    output logic            config_out,
    output logic            config_en,
    output logic            config_clr,
    output logic            busy,
    output logic            done
);

    localparam int BITS_W = $clog2(CHAIN_LEN + 1);
    localparam int CNT_W  = $clog2(size + 1);

    cfg_ld_state_t     state_r;
    cfg_ld_state_t     state_nxt_s;
    logic [BITS_W-1:0] bits_left_r;
    logic [BITS_W-1:0] bits_left_nxt_s;
    logic [CNT_W-1:0]  cnt_load_s;
    logic              ser_load_s;
    logic              ser_shift_s;
    logic              ser_last_s;
    logic              ser_head_s;

    cfg_serializer #(
        .size  (size),
        .CNT_W (CNT_W)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load_s),
        .shift     (ser_shift_s),
        .word_in   (word_in),
        .cnt_in    (cnt_load_s),
        .last      (ser_last_s),
        .head_next (ser_head_s)
    );

    // Bits to take from the next word: a full word, or what remains of the chain.
    always_comb begin
        if (32'(bits_left_r) >= size) begin
            cnt_load_s = CNT_W'(size);
        end else begin
            cnt_load_s = CNT_W'(bits_left_r);
        end
    end

    // Next-state, remaining-bit count and serializer controls.
    always_comb begin
        state_nxt_s     = state_r;
        bits_left_nxt_s = bits_left_r;
        ser_load_s      = 1'b0;
        ser_shift_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s     = CLEAR;
                    bits_left_nxt_s = BITS_W'(CHAIN_LEN);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                state_nxt_s = FETCH;
            end
            FETCH: begin
                if (word_valid && word_ready) begin
                    ser_load_s  = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            SHIFT: begin
                ser_shift_s     = 1'b1;
                bits_left_nxt_s = bits_left_r - BITS_W'(1'b1);
                if (ser_last_s) begin
                    if (bits_left_r == BITS_W'(1'b1)) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            FINISH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s     = IDLE;
                bits_left_nxt_s = '0;
            end
        endcase
    end

    // State and remaining-bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            bits_left_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            bits_left_r <= bits_left_nxt_s;
        end
    end

    // Outputs are decoded from the state being entered, so each is aligned
    // with its state and no input reaches an output without a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_ready <= 1'b0;
            config_clr <= 1'b0;
            config_en  <= 1'b0;
            config_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            word_ready <= (state_nxt_s == FETCH);
            config_clr <= (state_nxt_s == CLEAR);
            config_en  <= (state_nxt_s == SHIFT);
            config_out <= (state_nxt_s == SHIFT) ? ser_head_s : 1'b0;
            busy       <= (state_nxt_s == CLEAR) || (state_nxt_s == FETCH) ||
                          (state_nxt_s == SHIFT);
            done       <= (state_nxt_s == FINISH);
        end
    end

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench: four loader instances (32/14, 16/40, 16/32, 32/1).
// Stimulus tasks push expected load results and bit sequences; a negedge
// monitor models each attached chain and checks whenever a DUT shifts or
// signals done.
module tb_config_chain_loader;

    localparam int LEN_C  [4] = '{14, 40, 32, 1};
    localparam int SIZE_C [4] = '{32, 16, 16, 32};

    typedef struct {
        int          dut;
        logic [63:0] chain;
        int          en;
        int          bursts;
        int          hs;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start_s      [4];
    logic        word_valid_s [4];
    logic [31:0] word_in_s    [4];
    logic        word_ready_s [4];
    logic        config_out_s [4];
    logic        config_en_s  [4];
    logic        config_clr_s [4];
    logic        busy_s       [4];
    logic        done_s       [4];

    int checks;
    int failures;

    exp_t        sb [$];
    logic        exp_bits [4][$];
    logic [63:0] chain_m   [4];
    int          en_cnt    [4];
    int          burst_cnt [4];
    int          hs_cnt    [4];
    logic        prev_en   [4];

    config_chain_loader #(.size(32), .CHAIN_LEN(14)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .word_in(word_in_s[0]),
        .word_valid(word_valid_s[0]), .word_ready(word_ready_s[0]),
        .config_out(config_out_s[0]), .config_en(config_en_s[0]),
        .config_clr(config_clr_s[0]), .busy(busy_s[0]), .done(done_s[0]));

    config_chain_loader #(.size(16), .CHAIN_LEN(40)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .word_in(word_in_s[1][15:0]),
        .word_valid(word_valid_s[1]), .word_ready(word_ready_s[1]),
        .config_out(config_out_s[1]), .config_en(config_en_s[1]),
        .config_clr(config_clr_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    config_chain_loader #(.size(16), .CHAIN_LEN(32)) dut2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .word_in(word_in_s[2][15:0]),
        .word_valid(word_valid_s[2]), .word_ready(word_ready_s[2]),
        .config_out(config_out_s[2]), .config_en(config_en_s[2]),
        .config_clr(config_clr_s[2]), .busy(busy_s[2]), .done(done_s[2]));

    config_chain_loader #(.size(32), .CHAIN_LEN(1)) dut3 (
        .clk(clk), .reset(reset), .start(start_s[3]), .word_in(word_in_s[3]),
        .word_valid(word_valid_s[3]), .word_ready(word_ready_s[3]),
        .config_out(config_out_s[3]), .config_en(config_en_s[3]),
        .config_clr(config_clr_s[3]), .busy(busy_s[3]), .done(done_s[3]));

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs(input int d);
        return {word_ready_s[d], config_out_s[d], config_en_s[d],
                config_clr_s[d], busy_s[d], done_s[d]};
    endfunction

    // Monitor: models each chain, checks every shifted bit and every done.
    initial begin
        exp_t e;
        logic b;
        for (int d = 0; d < 4; d++) begin
            chain_m[d] = 64'h0; en_cnt[d] = 0; burst_cnt[d] = 0;
            hs_cnt[d] = 0; prev_en[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (reset) begin
                    prev_en[d] = 1'b0;
                end else begin
                    if (config_clr_s[d]) begin
                        chain_m[d] = 64'h0; en_cnt[d] = 0;
                        burst_cnt[d] = 0; hs_cnt[d] = 0;
                    end
                    if (config_en_s[d]) begin
                        chain_m[d] = (chain_m[d] >> 1) |
                                     (64'(config_out_s[d]) << (LEN_C[d] - 1));
                        en_cnt[d]++;
                        if (!prev_en[d]) burst_cnt[d]++;
                        if (exp_bits[d].size() == 0) begin
                            chk($sformatf("dut%0d_unexpected_shift", d), 64'(config_en_s[d]), 64'h0);
                        end else begin
                            b = exp_bits[d].pop_front();
                            chk($sformatf("dut%0d_config_out_bit%0d", d, en_cnt[d] - 1),
                                64'(config_out_s[d]), 64'(b));
                        end
                    end
                    if (word_valid_s[d] && word_ready_s[d]) hs_cnt[d]++;
                    if (done_s[d]) begin
                        if (sb.size() == 0) begin
                            chk($sformatf("dut%0d_unexpected_done", d), 64'(done_s[d]), 64'h0);
                        end else begin
                            e = sb.pop_front();
                            chk($sformatf("dut%0d_done_dut", d), 64'(d), 64'(e.dut));
                            chk($sformatf("dut%0d_chain", d), chain_m[d], e.chain);
                            chk($sformatf("dut%0d_en_cycles", d), 64'(en_cnt[d]), 64'(e.en));
                            chk($sformatf("dut%0d_bursts", d), 64'(burst_cnt[d]), 64'(e.bursts));
                            chk($sformatf("dut%0d_handshakes", d), 64'(hs_cnt[d]), 64'(e.hs));
                            chk($sformatf("dut%0d_done_after_en", d), 64'(prev_en[d]), 64'h1);
                        end
                    end
                    prev_en[d] = config_en_s[d];
                end
            end
        end
    end

    // One full load on DUT d. Entered and left at posedge+1.
    task automatic run_load(input int d, input int nw,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input int gap, input logic [63:0] exp_chain,
                            input bit poke_start, input int abort_en);
        logic [31:0] w [3];
        logic [31:0] ww;
        int n;
        bit seen_ready;
        exp_t e;
        w[0] = w0; w[1] = w1; w[2] = w2;
        exp_bits[d].delete();
        for (int k = 0; k < LEN_C[d]; k++) begin
            ww = w[k / SIZE_C[d]];
            exp_bits[d].push_back(ww[k % SIZE_C[d]]);
        end
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        chk($sformatf("dut%0d_clr_t1", d), 64'(config_clr_s[d]), 64'h1);
        chk($sformatf("dut%0d_busy_t1", d), 64'(busy_s[d]), 64'h1);
        @(posedge clk); #1;
        chk($sformatf("dut%0d_ready_t2", d), 64'(word_ready_s[d]), 64'h1);
        chk($sformatf("dut%0d_clr_one_cycle", d), 64'(config_clr_s[d]), 64'h0);
        for (int k = 0; k < nw; k++) begin
            n = 0;
            while (word_ready_s[d] !== 1'b1 && n < 200) begin
                @(posedge clk); #1; n++;
            end
            if (word_ready_s[d] !== 1'b1) begin
                chk($sformatf("dut%0d_ready_timeout", d), 64'(word_ready_s[d]), 64'h1);
                return;
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                chk($sformatf("dut%0d_hold_en", d), 64'(config_en_s[d]), 64'h0);
                chk($sformatf("dut%0d_hold_ready", d), 64'(word_ready_s[d]), 64'h1);
            end
            word_in_s[d] = w[k];
            word_valid_s[d] = 1'b1;
            @(posedge clk); #1;
            word_valid_s[d] = 1'b0;
            word_in_s[d] = 32'h0;
            chk($sformatf("dut%0d_en_after_hs", d), 64'(config_en_s[d]), 64'h1);
            chk($sformatf("dut%0d_ready_low_in_shift", d), 64'(word_ready_s[d]), 64'h0);
            if (abort_en > 0) begin
                for (int a = 1; a < abort_en; a++) begin
                    @(posedge clk); #1;
                end
                chk($sformatf("dut%0d_en_before_reset", d), 64'(config_en_s[d]), 64'h1);
                #2 reset = 1'b1;
                #1;
                chk($sformatf("dut%0d_outputs_in_reset", d), 64'(outs(d)), 64'h0);
                exp_bits[d].delete();
                @(posedge clk); #1;
                @(posedge clk); #3;
                reset = 1'b0;
                @(posedge clk); #1;
                chk($sformatf("dut%0d_idle_after_reset", d), 64'(outs(d)), 64'h0);
                return;
            end
            if (poke_start && k == 0) begin
                start_s[d] = 1'b1;
                @(posedge clk); #1;
                start_s[d] = 1'b0;
            end
        end
        e.dut = d; e.chain = exp_chain; e.en = LEN_C[d]; e.bursts = nw; e.hs = nw;
        sb.push_back(e);
        n = 0;
        seen_ready = 1'b0;
        while (done_s[d] !== 1'b1 && n < 300) begin
            if (word_ready_s[d]) seen_ready = 1'b1;
            @(posedge clk); #1; n++;
        end
        chk($sformatf("dut%0d_no_extra_ready", d), 64'(seen_ready), 64'h0);
        chk($sformatf("dut%0d_done_seen", d), 64'(done_s[d]), 64'h1);
        if (done_s[d] !== 1'b1) begin
            if (sb.size() > 0) sb.delete(sb.size() - 1);
            return;
        end
        chk($sformatf("dut%0d_busy_low_at_done", d), 64'(busy_s[d]), 64'h0);
        if (poke_start) start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        chk($sformatf("dut%0d_done_one_cycle", d), 64'(done_s[d]), 64'h0);
        chk($sformatf("dut%0d_no_clr_after_done", d), 64'(config_clr_s[d]), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk($sformatf("dut%0d_idle_after_load", d), 64'(outs(d)), 64'h0);
    endtask

    // Directed sequence.
    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        for (int d = 0; d < 4; d++) begin
            start_s[d] = 1'b0; word_valid_s[d] = 1'b0; word_in_s[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) chk($sformatf("dut%0d_reset_outputs", d), 64'(outs(d)), 64'h0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) chk($sformatf("dut%0d_idle_after_init", d), 64'(outs(d)), 64'h0);

        run_load(0, 1, 32'h0000_2A5F, 32'h0, 32'h0, 0, 64'h2A5F, 1'b0, 0);
        run_load(1, 3, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_00A5, 0, 64'hA5_0000_FFFF, 1'b0, 0);
        run_load(2, 2, 32'h0000_1234, 32'h0000_BEEF, 32'h0, 5, 64'hBEEF_1234, 1'b0, 0);
        run_load(0, 1, 32'hFFFF_C003, 32'h0, 32'h0, 0, 64'h0003, 1'b1, 0);
        run_load(0, 1, 32'h0000_1555, 32'h0, 32'h0, 0, 64'h1555, 1'b0, 0);
        run_load(1, 3, 32'h0000_1111, 32'h0000_2222, 32'h0000_0033, 0, 64'h0, 1'b0, 5);
        run_load(1, 3, 32'h0000_0F0F, 32'h0000_F0F0, 32'h0000_005A, 0, 64'h5A_F0F0_0F0F, 1'b0, 0);
        run_load(3, 1, 32'hFFFF_FFFE, 32'h0, 32'h0, 0, 64'h0, 1'b0, 0);
        run_load(3, 1, 32'h0000_0001, 32'h0, 32'h0, 0, 64'h1, 1'b0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a wait escapes its bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
